// File: rtl/sn_reg_ctrl_pkg.sv
// Shared types and constants for the SN76489-style register front end.
package sn_reg_ctrl_pkg;

    localparam int DEFAULT_PRESCALE    = 16;
    localparam int DEFAULT_BUSY_CYCLES = 32;

    localparam logic [3:0] ATTEN_OFF = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CH_TONE0 = 2'd0,
        CH_TONE1 = 2'd1,
        CH_TONE2 = 2'd2,
        CH_NOISE = 2'd3
    } channel_t;

    // Matches wr_data[6:4] of a latch byte: {channel[1:0], type}.
    typedef struct packed {
        channel_t channel;
        logic     is_atten;
    } latch_t;

    localparam latch_t LATCH_RESET = '{channel: CH_TONE0, is_atten: 1'b0};

endpackage

// File: rtl/sn_prescaler.sv
// Free-running divider: tick is high for one cycle every PRESCALE clocks.
module sn_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sn_reg_ctrl.sv
// SN76489-format command decoder with write-busy pacing and tone clock enable.
module sn_reg_ctrl
    import sn_reg_ctrl_pkg::*;
#(
    parameter int PRESCALE    = DEFAULT_PRESCALE,
    parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       tone_clk,
    output logic [9:0] freq0,
    output logic [9:0] freq1,
    output logic [9:0] freq2,
    output logic [3:0] atten0,
    output logic [3:0] atten1,
    output logic [3:0] atten2,
    output logic [3:0] atten3,
    output logic [2:0] noise_ctrl,
    output logic       noise_rst,
    output logic       overrun
);

    localparam logic [7:0] BUSY_LAST = 8'(BUSY_CYCLES - 1);

    state_t     state;
    latch_t     latch;
    latch_t     tgt;
    logic [7:0] busy_cnt;
    logic       is_latch;
    logic       accept;

    sn_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tone_clk)
    );

    // A data byte reuses the previously latched register as its target.
    assign is_latch = wr_data[7];
    assign tgt      = is_latch ? latch_t'(wr_data[6:4]) : latch;
    assign accept   = wr_en && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            busy_cnt   <= '0;
            latch      <= LATCH_RESET;
            freq0      <= '0;
            freq1      <= '0;
            freq2      <= '0;
            atten0     <= ATTEN_OFF;
            atten1     <= ATTEN_OFF;
            atten2     <= ATTEN_OFF;
            atten3     <= ATTEN_OFF;
            noise_ctrl <= '0;
            noise_rst  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            noise_rst <= 1'b0;
            if (wr_en && !ready) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_BUSY;
                        ready    <= 1'b0;
                        busy_cnt <= BUSY_LAST;
                        if (is_latch) begin
                            latch <= tgt;
                        end
                        if (tgt.is_atten) begin
                            case (tgt.channel)
                                CH_TONE0: atten0 <= wr_data[3:0];
                                CH_TONE1: atten1 <= wr_data[3:0];
                                CH_TONE2: atten2 <= wr_data[3:0];
                                default:  atten3 <= wr_data[3:0];
                            endcase
                        end else begin
                            case (tgt.channel)
                                CH_TONE0: if (is_latch) freq0[3:0] <= wr_data[3:0];
                                          else          freq0[9:4] <= wr_data[5:0];
                                CH_TONE1: if (is_latch) freq1[3:0] <= wr_data[3:0];
                                          else          freq1[9:4] <= wr_data[5:0];
                                CH_TONE2: if (is_latch) freq2[3:0] <= wr_data[3:0];
                                          else          freq2[9:4] <= wr_data[5:0];
                                default: begin
                                    noise_ctrl <= wr_data[2:0];
                                    noise_rst  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    // Busy lasts BUSY_CYCLES cycles: counter walks BUSY_LAST down to 0.
                    if (busy_cnt == 8'd0) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_reg_ctrl.sv
// Directed bench for sn_reg_ctrl with default PRESCALE=16, BUSY_CYCLES=32.
module tb_sn_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready;
    logic       tone_clk;
    logic [9:0] freq0, freq1, freq2;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic [2:0] noise_ctrl;
    logic       noise_rst;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    sn_reg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ready      (ready),
        .tone_clk   (tone_clk),
        .freq0      (freq0),
        .freq1      (freq1),
        .freq2      (freq2),
        .atten0     (atten0),
        .atten1     (atten1),
        .atten2     (atten2),
        .atten3     (atten3),
        .noise_ctrl (noise_ctrl),
        .noise_rst  (noise_rst),
        .overrun    (overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for a single edge; returns at #1 after that edge (cycle N+1).
    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until ready is seen high, bounded.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (!ready && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    int edges;

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset values, observed while reset is held.
        step(2);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_atten0", atten0, 4'hF);
        check_eq("rst_atten1", atten1, 4'hF);
        check_eq("rst_atten2", atten2, 4'hF);
        check_eq("rst_atten3", atten3, 4'hF);
        check_eq("rst_freq0", freq0, 0);
        check_eq("rst_freq1", freq1, 0);
        check_eq("rst_freq2", freq2, 0);
        check_eq("rst_noise_ctrl", noise_ctrl, 0);
        check_eq("rst_noise_rst", noise_rst, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_tone_clk", tone_clk, 0);

        // Release, then tone_clk high exactly at cycles 15, 31, 47.
        rst_n = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            check_eq($sformatf("tone_clk_c%0d", k), tone_clk, (k % 16) == 15);
            step(1);
        end

        // Tone 0 freq: latch low nibble, then data high bits.
        write_byte(8'h8E);
        check_eq("w8E_freq0", freq0, 10'h00E);
        check_eq("w8E_ready_low", ready, 0);
        wait_ready(edges);
        check_eq("w8E_busy_len", edges, 32);
        write_byte(8'h0F);
        check_eq("w0F_freq0", freq0, 10'h0FE);
        wait_ready(edges);
        check_eq("w0F_busy_len", edges, 32);

        // Attenuation 1.
        write_byte(8'hBF);
        check_eq("wBF_atten1", atten1, 4'hF);
        wait_ready(edges);
        write_byte(8'h05);
        check_eq("w05_atten1", atten1, 4'h5);
        check_eq("w05_freq0", freq0, 10'h0FE);
        check_eq("w05_freq1", freq1, 0);
        check_eq("w05_atten0", atten0, 4'hF);
        wait_ready(edges);

        // Noise control with reseed pulses.
        write_byte(8'hE4);
        check_eq("wE4_noise_ctrl", noise_ctrl, 3'b100);
        check_eq("wE4_noise_rst", noise_rst, 1);
        step(1);
        check_eq("wE4_noise_rst_end", noise_rst, 0);
        wait_ready(edges);
        check_eq("wE4_busy_rest", edges, 31);
        write_byte(8'h03);
        check_eq("w03_noise_ctrl", noise_ctrl, 3'b011);
        check_eq("w03_noise_rst", noise_rst, 1);
        check_eq("w03_freq0", freq0, 10'h0FE);
        step(1);
        check_eq("w03_noise_rst_end", noise_rst, 0);
        check_eq("w03_overrun", overrun, 0);
        wait_ready(edges);

        // Dropped write during busy.
        do_reset();
        write_byte(8'h81);
        check_eq("w81_freq0", freq0, 10'h001);
        step(9);
        write_byte(8'h3F);
        check_eq("drop_freq0", freq0, 10'h001);
        check_eq("drop_overrun", overrun, 1);
        check_eq("drop_ready", ready, 0);
        wait_ready(edges);
        check_eq("drop_ready_at_n33", edges, 22);
        // Latch still points at tone 0 freq: data byte sets freq0[9:4].
        write_byte(8'h2A);
        check_eq("after_drop_freq0", freq0, 10'h2A1);
        check_eq("overrun_sticky", overrun, 1);
        wait_ready(edges);

        // Reset during busy, then accept on the first edge after release.
        write_byte(8'hC5);
        check_eq("wC5_freq2", freq2, 10'h005);
        step(4);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_ready", ready, 1);
        check_eq("abort_freq2", freq2, 0);
        check_eq("abort_freq0", freq0, 0);
        check_eq("abort_overrun", overrun, 0);
        check_eq("abort_atten1", atten1, 4'hF);
        check_eq("abort_noise_ctrl", noise_ctrl, 0);
        step(1);
        #1;
        rst_n = 1'b1;
        write_byte(8'h9A);
        check_eq("w9A_atten0", atten0, 4'hA);
        check_eq("w9A_ready_low", ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
